// File: rtl/spi_master_multi.sv
// Multi-slave SPI master with per-transfer mode, bit order and divided sck.
// Ports: SCLK/reset, start+slave_select+mode+tx_data in; rx_data, busy, done, sel_err, sck, cs_n, mosi out; miso in.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV = 2,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slave_select,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_err,
  output logic                  sck,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * DATA_WIDTH);
  localparam logic [SEL_W:0] NS = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [KW-1:0]         k;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [NUM_SLAVES-1:0] cs_dec;
  logic                  sel_ok;
  logic                  period_end;
  logic                  do_edge;
  logic                  sample;
  logic                  drive;

  function automatic logic first_bit(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  lsb
  );
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  lsb
  );
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  b,
    input logic                  lsb
  );
    return lsb ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
  endfunction

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (slave_select == SEL_W'(i)) cs_dec[i] = 1'b0;
  end

  assign sel_ok = {1'b0, slave_select} < NS;
  assign period_end = (cnt == CNT_LAST);

  // k counts sck edges; even k is a leading edge. The last XFER
  // half-period (k == K_LAST) keeps sck idle before HOLD.
  assign do_edge = period_end &&
                   ((state == SETUP) ||
                    ((state == XFER) && (k != K_LAST)));
  assign sample = ~k[0] ^ cpha_q;
  assign drive = ~sample && (k != K_LAST - 1'b1);

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sel_err <= 1'b0;
      sck     <= 1'b0;
      cs_n    <= '1;
      mosi    <= 1'b0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      unique case (state)
        IDLE: begin
          sck <= cpol;
          cnt <= '0;
          k   <= '0;
          if (start) begin
            if (sel_ok) begin
              state  <= SETUP;
              busy   <= 1'b1;
              cs_n   <= cs_dec;
              cpha_q <= cpha;
              lsb_q  <= lsb_first;
              rx_sh  <= '0;
              if (!cpha) begin
                mosi  <= first_bit(tx_data, lsb_first);
                tx_sh <= shift_out(tx_data, lsb_first);
              end else begin
                tx_sh <= tx_data;
              end
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          cnt <= period_end ? '0 : cnt + 1'b1;
          if (period_end) state <= XFER;
        end
        XFER: begin
          cnt <= period_end ? '0 : cnt + 1'b1;
          if (period_end && (k == K_LAST)) state <= HOLD;
        end
        HOLD: begin
          cnt <= period_end ? '0 : cnt + 1'b1;
          if (period_end) begin
            state   <= IDLE;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_edge) begin
        sck <= ~sck;
        k   <= k + 1'b1;
        if (sample) rx_sh <= shift_in(rx_sh, miso, lsb_q);
        if (drive) begin
          mosi  <= first_bit(tx_sh, lsb_q);
          tx_sh <= shift_out(tx_sh, lsb_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: vector table, slave model, rx scoreboard.
// Covers all modes, bit orders, bad select, reset abort, back-to-back.
module tb_spi_master_multi;

  localparam int W  = 8;
  localparam int CD = 2;
  localparam int N  = CD * (2 * W + 2);

  logic       SCLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] slave_select = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sel_err;
  logic       sck;
  logic [2:0] cs_n;
  logic       mosi;
  logic       miso;

  always #5 SCLK = ~SCLK;

  spi_master_multi #(
    .DATA_WIDTH(W),
    .NUM_SLAVES(3),
    .CLK_DIV(CD)
  ) dut (
    .SCLK(SCLK),
    .reset(reset),
    .start(start),
    .slave_select(slave_select),
    .cpol(cpol),
    .cpha(cpha),
    .lsb_first(lsb_first),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .sel_err(sel_err),
    .sck(sck),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: mode-aware, drives s_resp and captures mosi.
  logic       loop_en = 1'b1;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic       s_lsb = 1'b0;
  logic [7:0] s_resp = '0;
  logic [7:0] s_cap = '0;
  logic       s_miso = 1'b0;
  int         s_idx = 0;
  logic       prev_sck = 1'b0;
  logic       prev_cs = 1'b1;

  function automatic logic rbit(input logic [7:0] r,
                                input logic lsb, input int i);
    return lsb ? r[i] : r[7-i];
  endfunction

  assign miso = loop_en ? mosi : s_miso;

  always @(negedge SCLK) begin
    prev_sck <= sck;
    prev_cs  <= &cs_n;
    if (&cs_n) begin
      s_idx <= 0;
    end else if (prev_cs) begin
      s_cap <= '0;
      if (!s_cpha) begin
        s_miso <= rbit(s_resp, s_lsb, 0);
        s_idx  <= 1;
      end else begin
        s_idx <= 0;
      end
    end else if (sck != prev_sck) begin
      if ((prev_sck == s_cpol) ^ s_cpha)
        s_cap <= s_lsb ? {mosi, s_cap[7:1]} : {s_cap[6:0], mosi};
      else if (s_idx < 8) begin
        s_miso <= rbit(s_resp, s_lsb, s_idx);
        s_idx  <= s_idx + 1;
      end
    end
  end

  // Scoreboard: expected rx words queued at start, popped at done.
  logic [7:0] exp_q[$];
  logic [7:0] exp_rx;
  int cyc = 0;

  always @(posedge SCLK) cyc <= cyc + 1;

  always @(negedge SCLK) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_rx = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(exp_rx));
      end
    end
  end

  typedef struct {
    logic [1:0] sel;
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic       loop;
    logic [7:0] tx;
    logic [7:0] resp;
    logic [2:0] exp_cs;
  } vec_t;

  vec_t vecs[6];

  task automatic set_mode(input vec_t v);
    @(negedge SCLK);
    cpol = v.cpol;
    cpha = v.cpha;
    lsb_first = v.lsb;
    slave_select = v.sel;
    tx_data = v.tx;
    loop_en = v.loop;
    s_cpol = v.cpol;
    s_cpha = v.cpha;
    s_lsb = v.lsb;
    s_resp = v.resp;
    @(negedge SCLK);
  endtask

  task automatic run_xfer(input vec_t v, input bit poke);
    int k;
    int cs_low;
    int rises;
    bit busy_ok;
    bit got;
    logic psck;
    set_mode(v);
    start = 1'b1;
    exp_q.push_back(v.loop ? v.tx : v.resp);
    @(posedge SCLK);
    #1;
    start = 1'b0;
    tx_data = ~v.tx;
    cpha = ~v.cpha;
    lsb_first = ~v.lsb;
    k = 0;
    cs_low = 0;
    rises = 0;
    busy_ok = 1'b1;
    got = 1'b0;
    psck = sck;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge SCLK);
      if (done) begin
        got = 1'b1;
        check("cs_n_at_done", 32'(cs_n), 32'h7);
        check("busy_at_done", 32'(busy), 32'(0));
        check("sck_idle", 32'(sck), 32'(v.cpol));
      end else begin
        if (cs_n == v.exp_cs) cs_low++;
        if (!busy) busy_ok = 1'b0;
        if (sck && !psck) rises++;
      end
      psck = sck;
      if (poke && k == 5) begin
        start = 1'b1;
        tx_data = 8'hEE;
      end
      if (poke && k == 6) start = 1'b0;
      if (!got) begin
        @(posedge SCLK);
        k++;
      end
    end
    check("done_seen", 32'(got), 32'(1));
    check("done_cycle", 32'(k), 32'(N));
    check("cs_low_cycles", 32'(cs_low), 32'(N));
    check("busy_during", 32'(busy_ok), 32'(1));
    check("sck_rises", 32'(rises), 32'(W));
    check("mosi_word", 32'(s_cap), 32'(v.tx));
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge SCLK);
      if (done) begin
        ok = 1'b1;
        t = cyc;
      end
    end
  endtask

  initial begin
    int t1;
    int t2;
    int hi;
    int sck_chg;
    int dones;
    bit ok;
    logic psck;

    vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 3'b110};
    vecs[1] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h3C, 3'b011};
    vecs[2] = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'hC3, 3'b101};
    vecs[3] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F, 8'hF0, 3'b110};
    vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 3'b101};
    vecs[5] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h96, 3'b011};

    #12;
    check("rst_cs_n", 32'(cs_n), 32'h7);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sel_err", 32'(sel_err), 32'(0));
    check("rst_rx", 32'(rx_data), 32'(0));
    check("rst_sck", 32'(sck), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    @(negedge SCLK);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0);

    // Invalid select.
    set_mode(vecs[0]);
    slave_select = 2'd3;
    start = 1'b1;
    @(posedge SCLK);
    #1;
    start = 1'b0;
    check("sel_err_pulse", 32'(sel_err), 32'(1));
    check("sel_err_busy", 32'(busy), 32'(0));
    check("sel_err_cs", 32'(cs_n), 32'h7);
    @(posedge SCLK);
    #1;
    check("sel_err_width", 32'(sel_err), 32'(0));
    sck_chg = 0;
    hi = 0;
    psck = sck;
    repeat (10) begin
      @(negedge SCLK);
      if (sck != psck) sck_chg++;
      if (cs_n == 3'b111 && !busy) hi++;
      psck = sck;
    end
    check("sel_err_no_sck", 32'(sck_chg), 32'(0));
    check("sel_err_idle", 32'(hi), 32'(10));

    // Reset in the middle of a transfer.
    set_mode(vecs[4]);
    start = 1'b1;
    @(posedge SCLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge SCLK);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n), 32'h7);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_rx", 32'(rx_data), 32'(0));
    check("midrst_sck", 32'(sck), 32'(0));
    repeat (2) @(negedge SCLK);
    reset = 1'b0;
    dones = 0;
    repeat (60) begin
      @(negedge SCLK);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'(0));
    run_xfer(vecs[0], 1'b0);

    // Back-to-back with start held high.
    set_mode('{2'd1, 1'b0, 1'b0, 1'b1, 1'b1,
               8'h12, 8'h00, 3'b101});
    start = 1'b1;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    @(posedge SCLK);
    #1;
    tx_data = 8'h34;
    wait_done(t1, ok);
    check("b2b_done1", 32'(ok), 32'(1));
    hi = 1;
    for (int i = 0; i < 10 && (&cs_n); i++) begin
      @(negedge SCLK);
      if (&cs_n) hi++;
    end
    start = 1'b0;
    check("b2b_cs_gap", 32'(hi), 32'(1));
    wait_done(t2, ok);
    check("b2b_done2", 32'(ok), 32'(1));
    check("b2b_spacing", 32'(t2 - t1), 32'(N + 1));

    // A second start while busy is ignored.
    run_xfer(vecs[2], 1'b1);
    dones = 0;
    repeat (45) begin
      @(negedge SCLK);
      if (done) dones++;
    end
    check("ignored_start", 32'(dones), 32'(0));
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
